// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding and default register-index width.
package pipeline_pkg;

    localparam int REG_ID_WIDTH = 5;

    typedef enum logic [1:0] {
        HZ_RUN           = 2'd0,
        HZ_MEM_WAIT      = 2'd1,
        HZ_REDIRECT_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags when the ID instruction reads the
// destination of a load currently in EX. Register x0 never matches.
module load_use_detect #(
    parameter int REG_ID_WIDTH = pipeline_pkg::REG_ID_WIDTH
) (
    input  logic [REG_ID_WIDTH-1:0] id_reg1_i,
    input  logic [REG_ID_WIDTH-1:0] id_reg2_i,
    input  logic                    id_use1_i,
    input  logic                    id_use2_i,
    input  logic [REG_ID_WIDTH-1:0] ex_dest_i,
    input  logic                    ex_mem_read_i,
    output logic                    hazard_o
);

    logic destValid;
    logic match1;
    logic match2;

    assign destValid = ex_mem_read_i && (ex_dest_i != '0);
    assign match1    = id_use1_i && (id_reg1_i == ex_dest_i);
    assign match2    = id_use2_i && (id_reg2_i == ex_dest_i);
    assign hazard_o  = destValid && (match1 || match2);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: combines data-cache stalls, EX redirects, instruction-cache
// misses and load-use hazards into per-stage stall/flush controls.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_unit #(
    parameter int REG_ID_WIDTH = pipeline_pkg::REG_ID_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REG_ID_WIDTH-1:0] id_reg1,
    input  logic [REG_ID_WIDTH-1:0] id_reg2,
    input  logic                    id_use1,
    input  logic                    id_use2,
    input  logic [REG_ID_WIDTH-1:0] ex_dest,
    input  logic                    ex_mem_read,
    input  logic                    ex_redirect,
    input  logic                    icache_busy,
    input  logic                    dcache_busy,
    output logic                    pc_stall,
    output logic                    if_id_stall,
    output logic                    id_ex_stall,
    output logic                    ex_mem_stall,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic                    mem_wb_flush,
    output logic [1:0]              hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    stall_cycles,
    output logic [CNT_WIDTH-1:0]    flush_events,
    output logic [CNT_WIDTH-1:0]    load_use_events
`endif
);

    import pipeline_pkg::*;

    hz_state_t state_q;
    hz_state_t state_d;
    logic      loadUse;

    load_use_detect #(
        .REG_ID_WIDTH (REG_ID_WIDTH)
    ) uLoadUse (
        .id_reg1_i     (id_reg1),
        .id_reg2_i     (id_reg2),
        .id_use1_i     (id_use1),
        .id_use2_i     (id_use2),
        .ex_dest_i     (ex_dest),
        .ex_mem_read_i (ex_mem_read),
        .hazard_o      (loadUse)
    );

    // State register; reset abandons any pending memory or redirect wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: reset, memory freeze, redirect, redirect wait, load-use, fetch miss.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = HZ_RUN;

        if (!reset) begin
            state_d = HZ_RUN;
        end else if (dcache_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = (state_q == HZ_REDIRECT_WAIT) ? HZ_REDIRECT_WAIT : HZ_MEM_WAIT;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = icache_busy ? HZ_REDIRECT_WAIT : HZ_RUN;
        end else if (state_q == HZ_REDIRECT_WAIT) begin
            if_id_flush = 1'b1;
            pc_stall    = icache_busy;
            state_d     = icache_busy ? HZ_REDIRECT_WAIT : HZ_RUN;
        end else if (loadUse) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (icache_busy) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stallCycles_q;
    logic [CNT_WIDTH-1:0] flushEvents_q;
    logic [CNT_WIDTH-1:0] loadUseEvents_q;
    logic                 redirectEvent;
    logic                 bubbleEvent;

    assign redirectEvent = if_id_flush && id_ex_flush;
    assign bubbleEvent   = if_id_stall && id_ex_flush;

    // Free-running event counters that wrap naturally at their width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles_q   <= '0;
            flushEvents_q   <= '0;
            loadUseEvents_q <= '0;
        end else begin
            if (pc_stall) begin
                stallCycles_q <= stallCycles_q + CNT_WIDTH'(1);
            end
            if (redirectEvent) begin
                flushEvents_q <= flushEvents_q + CNT_WIDTH'(1);
            end
            if (bubbleEvent) begin
                loadUseEvents_q <= loadUseEvents_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles    = stallCycles_q;
    assign flush_events    = flushEvents_q;
    assign load_use_events = loadUseEvents_q;
`endif

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ID_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each performance counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_reg1, id_reg2  input  REG_ID_WIDTH  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use1, id_use2  input  1  the ID instruction reads reg1/reg2.
REQ-007 SHALL have ports ex_dest  input  REG_ID_WIDTH, and ex_mem_read  input  1, which together describe a load in EX.
REQ-008 SHALL have port ex_redirect  input  1  taken branch/jump resolved in EX.
REQ-009 SHALL have ports icache_busy, dcache_busy  input  1  fetch/memory access not yet complete.
REQ-010 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1  hold the stage register.
REQ-011 SHALL have ports if_id_flush, id_ex_flush, mem_wb_flush  output  1  load a bubble into the stage register.
REQ-012 SHALL have port hz_state  output  2  current FSM state, for debug.

Function
REQ-013 All outputs SHALL be combinational from current state and inputs (zero-cycle latency); only the FSM state and counters are registered.
REQ-014 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, REDIRECT_WAIT=2; encoding 3 is unreachable and SHALL recover to RUN.
REQ-015 Memory stall has top priority: while dcache_busy=1, the unit SHALL assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush, and SHALL deassert all other flushes.
REQ-016 RUN->MEM_WAIT SHALL occur when dcache_busy=1; MEM_WAIT->RUN SHALL occur on the first cycle with dcache_busy=0, and outputs in that cycle SHALL follow the RUN rules.
REQ-017 ex_redirect SHALL be honoured only in cycles where dcache_busy=0; because EX is frozen during a memory stall, the redirect is held and is acted on afterwards.
REQ-018 On an honoured redirect the unit SHALL assert if_id_flush and id_ex_flush, and SHALL deassert pc_stall.
REQ-019 An honoured redirect with icache_busy=1 SHALL move the FSM to REDIRECT_WAIT.
REQ-020 In REDIRECT_WAIT the unit SHALL assert if_id_flush every cycle while icache_busy=1.
REQ-021 REDIRECT_WAIT SHALL assert if_id_flush for one further cycle when icache_busy falls, to discard the wrong-path return, and SHALL then return to RUN.
REQ-022 A load-use hazard SHALL be detected when ex_mem_read=1, ex_dest!=0, and (id_use1 and id_reg1==ex_dest, or id_use2 and id_reg2==ex_dest).
REQ-023 On a load-use hazard with no memory stall and no redirect, the unit SHALL assert pc_stall and if_id_stall, and SHALL assert id_ex_flush (one-cycle bubble).
REQ-024 Register x0 SHALL never cause a hazard.
REQ-025 A redirect SHALL suppress load-use handling in the same cycle, because the ID instruction is being flushed.
REQ-026 In RUN with icache_busy=1 and no other event, the unit SHALL assert pc_stall and if_id_flush.
REQ-027 A stall and a flush SHALL never be asserted together on the same stage register.

Reset
REQ-028 While reset=0, the FSM SHALL be RUN, all counters 0, and all stall/flush outputs 0, immediately and independent of clk.
REQ-029 Reset asserted mid-MEM_WAIT or mid-REDIRECT_WAIT SHALL abandon the pending operation; no flush SHALL be replayed after release.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined, the unit SHALL add outputs stall_cycles, flush_events and load_use_events (each CNT_WIDTH).
REQ-031 With HAZARD_PERF_CNT_EN defined, stall_cycles SHALL increment on each cycle with pc_stall=1.
REQ-032 With HAZARD_PERF_CNT_EN defined, flush_events SHALL increment on each honoured redirect, and load_use_events on each load-use bubble.
REQ-033 With HAZARD_PERF_CNT_EN defined, all three counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-034 Without HAZARD_PERF_CNT_EN, the counter ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 The state enum (hz_state_t) and state encodings SHALL reside in shared package pipeline_pkg, alongside REG_ID_WIDTH.
REQ-036 Load-use comparison SHALL be a sub-module named load_use_detect (combinational); the FSM and counters stay in the top module.

Verification
REQ-037 Load x5 in EX with id_reg2=5 and id_use2=1 SHALL produce, in the same cycle, pc_stall=1, if_id_stall=1, id_ex_flush=1; the next cycle (EX now a non-load) SHALL have all outputs 0.
REQ-038 Load to x0 with id_reg1=0 and id_use1=1 SHALL produce all outputs 0.
REQ-039 dcache_busy high for 3 cycles with ex_redirect=1 SHALL produce 3 cycles of the freeze pattern, then one cycle with if_id_flush=1 and id_ex_flush=1; hz_state SHALL read 1,1,1,0.
REQ-040 ex_redirect with icache_busy=1 for 2 further cycles SHALL hold if_id_flush=1 for 4 cycles in total; hz_state SHALL read 2 during the wait and 0 afterwards.
REQ-041 Reset pulsed low in REDIRECT_WAIT SHALL immediately deassert all outputs and set hz_state=0.
REQ-042 With HAZARD_PERF_CNT_EN and CNT_WIDTH=4, 17 stall cycles SHALL leave stall_cycles=1.
